// File: rtl/regfile_pkg.sv
// Shared constants and read-source selection for the architectural register file.
package regfile_pkg;

  localparam int REG_DATA_W = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_NUM    = 32;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_MEM    = 2'd2
  } rd_src_e;

  // Read-port priority: reset, disabled port and $0 all read zero;
  // a same-cycle write to the addressed entry beats storage.
  function automatic rd_src_e rd_src_sel(input logic rst, input logic re,
                                         input logic addr_zero, input logic wr_hit);
    rd_src_e src;
    if (rst || !re || addr_zero) src = SRC_ZERO;
    else if (wr_hit)             src = SRC_BYPASS;
    else                         src = SRC_MEM;
    return src;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Outstanding-write scoreboard for the register file; only present when
// REGFILE_SCOREBOARD_EN is defined.
`ifdef REGFILE_SCOREBOARD_EN
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              busy1,
  output logic              busy2
);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;

  // Set is applied after clear so a newly issued producer wins over the retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (we && (waddr != '0))           w_busy_nxt[waddr]      = 1'b0;
    if (issue_en && (issue_addr != '0)) w_busy_nxt[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // A write-back landing this cycle is forwarded by the bypass, so it is no hazard.
  assign busy1 = re1 && (raddr1 != '0) && r_busy[raddr1] && !(we && (waddr == raddr1));
  assign busy2 = re2 && (raddr2 != '0) && r_busy[raddr2] && !(we && (waddr == raddr2));

endmodule
`endif

// File: rtl/regfile.sv
// 32 x 32-bit register file: synchronous write, combinational read with write-through
// bypass. Define REGFILE_SCOREBOARD_EN to add the busy scoreboard ports.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W   = REG_DATA_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
`ifdef REGFILE_SCOREBOARD_EN
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              busy1,
  output logic              busy2,
`endif
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];
  logic              w_wr_ok;
  rd_src_e           w_src1;
  rd_src_e           w_src2;

  function automatic logic [DATA_W-1:0] rd_mux(input rd_src_e src,
                                               input logic [DATA_W-1:0] byp,
                                               input logic [DATA_W-1:0] mem);
    logic [DATA_W-1:0] res;
    case (src)
      SRC_BYPASS: res = byp;
      SRC_MEM:    res = mem;
      default:    res = '0;
    endcase
    return res;
  endfunction

  assign w_wr_ok = we && (waddr != '0);

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign w_src1 = rd_src_sel(rst, re1, raddr1 == '0, we && (waddr == raddr1));
  assign w_src2 = rd_src_sel(rst, re2, raddr2 == '0, we && (waddr == raddr2));

  assign rdata1 = rd_mux(w_src1, wdata, r_mem[raddr1]);
  assign rdata2 = rd_mux(w_src2, wdata, r_mem[raddr2]);

`ifdef REGFILE_SCOREBOARD_EN
  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .we         (we),
    .waddr      (waddr),
    .re1        (re1),
    .raddr1     (raddr1),
    .re2        (re2),
    .raddr2     (raddr2),
    .busy1      (busy1),
    .busy2      (busy2)
  );
`endif

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed steps followed by random traffic,
// compared against an array-based model of the register file.
module tb_regfile;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
`ifdef REGFILE_SCOREBOARD_EN
  logic          issue_en;
  logic [AW-1:0] issue_addr;
  logic          busy1;
  logic          busy2;
  bit            sb_busy [32];
`endif

  logic [DW-1:0] model [32];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re1        (re1),
    .raddr1     (raddr1),
    .rdata1     (rdata1),
    .re2        (re2),
    .raddr2     (raddr2),
`ifdef REGFILE_SCOREBOARD_EN
    .issue_en   (issue_en),
    .issue_addr (issue_addr),
    .busy1      (busy1),
    .busy2      (busy2),
`endif
    .rdata2     (rdata2)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read value straight from the port rules.
  function automatic logic [DW-1:0] exp_rd(input logic re, input logic [AW-1:0] a);
    if (rst || !re || a == 0) return '0;
    if (we && waddr == a)     return wdata;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
`ifdef REGFILE_SCOREBOARD_EN
    for (int i = 0; i < 32; i++) sb_busy[i] = 1'b0;
`endif
  endtask

  task automatic set_wr(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = w; waddr = a; wdata = d;
  endtask

  task automatic set_rd(input logic e1, input logic [AW-1:0] a1,
                        input logic e2, input logic [AW-1:0] a2);
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
  endtask

  // Check outputs before the edge, advance one clock, update the model.
  task automatic tick(input string tag);
    #1;
    check({tag, ".rd1"}, rdata1, exp_rd(re1, raddr1));
    check({tag, ".rd2"}, rdata2, exp_rd(re2, raddr2));
`ifdef REGFILE_SCOREBOARD_EN
    check({tag, ".busy1"}, DW'(busy1),
          DW'(!rst && re1 && raddr1 != 0 && sb_busy[raddr1] && !(we && waddr == raddr1)));
    check({tag, ".busy2"}, DW'(busy2),
          DW'(!rst && re2 && raddr2 != 0 && sb_busy[raddr2] && !(we && waddr == raddr2)));
`endif
    @(posedge clk);
    if (!rst) begin
      if (we && waddr != 0) model[waddr] = wdata;
`ifdef REGFILE_SCOREBOARD_EN
      if (we && waddr != 0) sb_busy[waddr] = 1'b0;
      if (issue_en && issue_addr != 0) sb_busy[issue_addr] = 1'b1;
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    set_wr(1'b0, 5'd0, '0);
    set_rd(1'b1, 5'd3, 1'b1, 5'd3);
`ifdef REGFILE_SCOREBOARD_EN
    issue_en = 1'b0; issue_addr = '0;
`endif
    clear_model();

    // Reset holds both ports at zero, and a write during reset is dropped.
    tick("reset_idle");
    set_wr(1'b1, 5'd3, 32'hAAAA_5555);
    #1;
    check("reset_rd1_zero", rdata1, 32'h0);
    check("reset_rd2_zero", rdata2, 32'h0);
    tick("reset_write");
    rst = 1'b0;
    set_wr(1'b0, 5'd0, '0);
    tick("post_reset_r3");

    // Write r5, then assert reset mid-cycle, including a mid-write attempt.
    set_wr(1'b1, 5'd5, 32'h1234_5678);
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    tick("w_r5");
    set_wr(1'b0, 5'd0, '0);
    set_rd(1'b1, 5'd5, 1'b1, 5'd5);
    #1;
    check("r5_before_rst", rdata1, 32'h1234_5678);
    #1;
    rst = 1'b1;
    clear_model();
    set_wr(1'b1, 5'd5, 32'hCAFE_F00D);
    #1;
    check("async_rst_rd1", rdata1, 32'h0);
    check("async_rst_rd2", rdata2, 32'h0);
    @(posedge clk);
    #1;
    check("rst_edge_rd1", rdata1, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    set_wr(1'b0, 5'd0, '0);
    #1;
    check("r5_after_rst", rdata1, 32'h0);
    tick("r5_after_rst_m");

    // Plain write then read, with the port enabled and disabled.
    set_wr(1'b1, 5'd7, 32'hDEAD_BEEF);
    set_rd(1'b0, 5'd0, 1'b0, 5'd0);
    tick("w_r7");
    set_wr(1'b0, 5'd0, '0);
    set_rd(1'b1, 5'd7, 1'b0, 5'd7);
    #1;
    check("r7_read", rdata1, 32'hDEAD_BEEF);
    check("r7_re2_off", rdata2, 32'h0);
    tick("r7_m");
    set_rd(1'b0, 5'd7, 1'b0, 5'd7);
    #1;
    check("r7_re1_off", rdata1, 32'h0);
    tick("r7_off_m");

    // Same-cycle bypass on both ports, then from storage.
    set_wr(1'b1, 5'd9, 32'h0000_00A5);
    set_rd(1'b1, 5'd9, 1'b1, 5'd9);
    #1;
    check("byp_rd1", rdata1, 32'h0000_00A5);
    check("byp_rd2", rdata2, 32'h0000_00A5);
    tick("byp_m");
    set_wr(1'b0, 5'd0, '0);
    #1;
    check("r9_stored", rdata1, 32'h0000_00A5);
    tick("r9_m");

    // Writes to $0 are discarded, even in the bypass cycle.
    set_wr(1'b1, 5'd0, 32'hFFFF_FFFF);
    set_rd(1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    check("r0_byp_rd1", rdata1, 32'h0);
    check("r0_byp_rd2", rdata2, 32'h0);
    tick("r0_m");
    set_wr(1'b0, 5'd0, '0);
    #1;
    check("r0_after", rdata2, 32'h0);
    tick("r0_after_m");

    // Independent dual-port reads, then swapped addresses.
    set_wr(1'b1, 5'd1, 32'h11);
    tick("w_r1");
    set_wr(1'b1, 5'd31, 32'h1F);
    tick("w_r31");
    set_wr(1'b0, 5'd0, '0);
    set_rd(1'b1, 5'd1, 1'b1, 5'd31);
    #1;
    check("dual_rd1", rdata1, 32'h11);
    check("dual_rd2", rdata2, 32'h1F);
    tick("dual_m");
    set_rd(1'b1, 5'd31, 1'b1, 5'd1);
    #1;
    check("swap_rd1", rdata1, 32'h1F);
    check("swap_rd2", rdata2, 32'h11);
    tick("swap_m");

`ifdef REGFILE_SCOREBOARD_EN
    // Scoreboard: issue sets, write-back clears (bypassed same cycle), set wins on collision.
    set_rd(1'b1, 5'd4, 1'b0, 5'd0);
    issue_en = 1'b1; issue_addr = 5'd4;
    tick("sb_issue4");
    issue_en = 1'b0;
    #1;
    check("sb_busy_set", DW'(busy1), 32'h1);
    tick("sb_busy_m");
    set_wr(1'b1, 5'd4, 32'h4444);
    #1;
    check("sb_wb_same", DW'(busy1), 32'h0);
    tick("sb_wb_m");
    set_wr(1'b0, 5'd0, '0);
    #1;
    check("sb_wb_after", DW'(busy1), 32'h0);
    tick("sb_after_m");
    issue_en = 1'b1; issue_addr = 5'd4;
    tick("sb_reissue");
    set_wr(1'b1, 5'd4, 32'h4545);
    tick("sb_collide");
    set_wr(1'b0, 5'd0, '0);
    issue_en = 1'b0;
    #1;
    check("sb_set_wins", DW'(busy1), 32'h1);
    tick("sb_set_wins_m");
`endif

    // Random traffic, reads biased towards the write address to exercise bypass.
    for (int n = 0; n < 400; n++) begin
      set_wr(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
      re1    = ($urandom_range(0, 3) != 0);
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      re2    = ($urandom_range(0, 3) != 0);
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
`ifdef REGFILE_SCOREBOARD_EN
      issue_en   = ($urandom_range(0, 2) == 0);
      issue_addr = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
`endif
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile.md
Name: regfile

Overview:
- Architectural general-purpose register file: 32 x 32-bit.
- Sits at the far end of the result path. Results leave the execute stage as (wd, wreg, wdata), pass through the MEM and WB stages, and are committed here.
- Sources the two operands the decode stage reads.
- Writes are synchronous. Reads are combinational, with write-through bypass, so a value written in WB is visible to ID in the same cycle.

Parameters:
- DATA_W, 32, register width (matches `RegBus).
- ADDR_W, 5, register address width (matches `RegAddrBus).
- NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset (`RstEnable = 1'b1).
- we  in  1  write enable from WB (`WriteEnable).
- waddr  in  ADDR_W  write register index (from WB wd).
- wdata  in  DATA_W  write data (from WB wdata).
- re1  in  1  read-port-1 enable from ID (`ReadEnable).
- raddr1  in  ADDR_W  read-port-1 index.
- rdata1  out  DATA_W  read-port-1 data.
- re2  in  1  read-port-2 enable.
- raddr2  in  ADDR_W  read-port-2 index.
- rdata2  out  DATA_W  read-port-2 data.
- Scoreboard ports exist only with the optional feature: see Optional Feature.

Behaviour:
- Reset:
  - rst=1 asynchronously clears all 32 storage entries to `ZeroWord.
  - rdata1 and rdata2 are forced to `ZeroWord while rst=1, independent of the read inputs.
- Write:
  - On posedge clk with rst=0, we=1 and waddr!=0, mem[waddr] <= wdata.
  - Writes with waddr==0 are discarded; register $0 always reads 0.
- Read port n (identical logic, priority in this order):
  - rst=1 -> 0.
  - re_n=0 -> 0.
  - raddr_n==0 -> 0.
  - we=1 and waddr==raddr_n -> wdata (bypass, same cycle, zero latency).
  - otherwise -> mem[raddr_n].
- Both ports may address the same register; both receive identical data, including bypassed data.
- Latency:
  - Read: 0 cycles (combinational).
  - Write: visible via storage from the cycle after the clock edge, and via bypass in the same cycle.
- Reset asserted mid-write: the write is lost and the entry reads 0 after reset deasserts.
- No X propagation: undriven or unwritten entries read 0 after reset.

Optional Feature:
- Macro: REGFILE_SCOREBOARD_EN.
- With the macro defined, add these ports:
  - issue_en  in  1  ID issues an instruction that will write a register.
  - issue_addr  in  ADDR_W  destination index of the issued instruction.
  - busy1  out  1  raddr1 has an outstanding write.
  - busy2  out  1  raddr2 has an outstanding write.
- Scoreboard state: 32-bit busy vector, cleared by rst.
- Update on posedge clk:
  - issue_en and issue_addr!=0 set busy[issue_addr].
  - we and waddr!=0 clear busy[waddr].
  - Same index set and cleared in the same cycle -> set wins, since the newer producer is pending.
- busy_n output:
  - busy_n = re_n & busy[raddr_n] & ~(we & waddr==raddr_n); a same-cycle write-back is bypassed, so it is not a hazard.
  - busy_n is always 0 for index 0.
- Without the macro: none of these ports or flops exist. Behaviour is otherwise identical.

Decomposition:
- Constants live in the shared define.v: `RegBus, `RegAddrBus, `RegNum (32), `RegNumLog2 (5), `ZeroWord, `NOPRegAddr, `WriteEnable, `ReadEnable, `RstEnable.
- Sub-module: regfile_scoreboard, which holds the busy vector and busy1/busy2 logic and is instantiated only under REGFILE_SCOREBOARD_EN.
- Storage, write logic and read/bypass muxes stay in regfile.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after writing 0x1234_5678 to r5; release; read r5 with re1=1 -> rdata1=0. During rst, rdata1=rdata2=0.
- Write/read: write 0xDEAD_BEEF to r7, next cycle re1=1, raddr1=7 -> 0xDEAD_BEEF. Same read with re1=0 -> 0.
- Bypass: in a single cycle, we=1, waddr=9, wdata=0x0000_00A5, raddr1=raddr2=9, re1=re2=1 -> both ports read 0x0000_00A5 before the clock edge; storage holds it after the edge.
- $0: write 0xFFFF_FFFF to r0 -> r0 reads 0 on both ports, including in the bypass cycle.
- Dual port: preload r1=0x11, r31=0x1F; read raddr1=1, raddr2=31 -> 0x11 / 0x1F; swap addresses -> swapped data.
- Scoreboard (REGFILE_SCOREBOARD_EN):
  - issue_en with issue_addr=4 -> next cycle busy1=1 for raddr1=4.
  - Write-back r4 -> busy1=0 in that same cycle, stays 0 afterwards.
  - Simultaneous issue and write-back to r4 -> busy stays 1.
